wn_dot: RTL and testbench

WN_DOT -- requirements
Module: wn_dot

---
 rtl/wn_dot_if.sv | 29 ++
 rtl/wn_dot.sv | 105 ++++++++++
 tb/tb_wn_dot.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wn_dot_if.sv
// Bus bundle for wn_dot: pass control, activation/weight memory read ports and results.
// The master side starts passes and serves memory reads; the slave side is the engine.
interface wn_dot_if #(
   parameter int unsigned NCH = 16,
   parameter int unsigned DW  = 8,
   parameter int unsigned AW  = 4,
   parameter int unsigned OW  = DW
);
   logic                        start;
   logic [AW-1:0]               len;
   logic                        relu;
   logic [AW-1:0]               x_raddr;
   logic signed [DW-1:0]        x_rdata;
   logic [NCH*AW-1:0]           w_raddr;
   logic signed [NCH*DW-1:0]    w_rdata;
   logic [NCH*OW-1:0]           y;
   logic                        busy;
   logic                        finish;

   modport master (
      output start, len, relu, x_rdata, w_rdata,
      input  x_raddr, w_raddr, y, busy, finish
   );

   modport slave (
      input  start, len, relu, x_rdata, w_rdata,
      output x_raddr, w_raddr, y, busy, finish
   );
endinterface

// File: rtl/wn_dot.sv
// NCH-channel signed dot-product engine: one shared activation stream against NCH weight
// streams, one term per cycle, with saturation and optional ReLU on the results.
module wn_dot #(
   parameter int unsigned NCH  = 16,
   parameter int unsigned DW   = 8,
   parameter int unsigned AW   = 4,
   parameter int unsigned ACCW = 2*DW+AW,
   parameter int unsigned OW   = DW
) (
   input logic       clk,
   input logic       xrst,
   wn_dot_if.slave   bus
);
   localparam int unsigned PW = 2*DW;
   localparam logic signed [ACCW-1:0] LP_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] LP_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [AW-1:0]           r_addr;
   logic [AW-1:0]           r_len_m1;
   logic                    r_relu;
   logic                    r_dv;
   logic                    r_busy;
   logic                    r_finish;
   logic [NCH*OW-1:0]       r_y;
   logic signed [ACCW-1:0]  r_acc     [NCH];
   logic signed [PW-1:0]    w_prod    [NCH];
   logic signed [ACCW-1:0]  w_acc_nxt [NCH];
   logic [NCH*OW-1:0]       w_y_nxt;

   function automatic logic [OW-1:0] f_sat(input logic signed [ACCW-1:0] a, input logic rl);
      if (rl && a[ACCW-1]) return '0;
      if (a > LP_MAX)      return LP_MAX[OW-1:0];
      if (a < LP_MIN)      return LP_MIN[OW-1:0];
      return a[OW-1:0];
   endfunction

   // State register
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state; len is latched as len-1 so len=0 naturally selects the full depth
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_nxt = ST_RUN;
         ST_RUN:   if (r_addr == r_len_m1) w_state_nxt = ST_DRAIN;
         ST_DRAIN: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-channel multiply-accumulate and result shaping
   always_comb begin
      w_prod    = '{default: '0};
      w_acc_nxt = '{default: '0};
      w_y_nxt   = '0;
      for (int c = 0; c < NCH; c++) begin
         w_prod[c]    = PW'($signed(bus.w_rdata[c*DW +: DW])) * PW'(bus.x_rdata);
         w_acc_nxt[c] = r_acc[c] + ACCW'(w_prod[c]);
         w_y_nxt[c*OW +: OW] = f_sat(w_acc_nxt[c], r_relu);
      end
   end

   // Datapath; r_dv marks read data returning one cycle after each RUN address
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_addr   <= '0;
         r_len_m1 <= '0;
         r_relu   <= 1'b0;
         r_dv     <= 1'b0;
         r_busy   <= 1'b0;
         r_finish <= 1'b0;
         r_y      <= '0;
         for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      end else begin
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_finish <= (r_state == ST_DRAIN);
         r_dv     <= (r_state == ST_RUN);
         if (r_state == ST_IDLE && bus.start) begin
            r_len_m1 <= AW'(bus.len - AW'(1));
            r_relu   <= bus.relu;
            r_addr   <= '0;
            for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
         end
         if (r_state == ST_RUN && r_addr != r_len_m1) r_addr <= r_addr + AW'(1);
         if (r_dv) begin
            for (int c = 0; c < NCH; c++) r_acc[c] <= w_acc_nxt[c];
         end
         if (r_state == ST_DRAIN) r_y <= w_y_nxt;
      end
   end

   assign bus.x_raddr = r_addr;
   assign bus.w_raddr = {NCH{r_addr}};
   assign bus.y       = r_y;
   assign bus.busy    = r_busy;
   assign bus.finish  = r_finish;
endmodule

// File: tb/tb_wn_dot.sv
// Directed bench for wn_dot: synchronous-read memory models behind the bus and
// hand-computed expected results, latencies and address sequences.
module tb_wn_dot;
   localparam int unsigned NCH = 16;
   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 4;
   localparam int unsigned OW  = 8;

   logic clk  = 1'b0;
   logic xrst = 1'b0;
   int   errs = 0;
   int   nchk = 0;
   int   fcyc;

   logic signed [DW-1:0] xmem [16];
   logic signed [DW-1:0] wmem [NCH][16];

   wn_dot_if #(.NCH(NCH), .DW(DW), .AW(AW), .OW(OW)) bus ();

   wn_dot #(.NCH(NCH), .DW(DW), .AW(AW), .ACCW(2*DW+AW), .OW(OW)) dut (
      .clk  (clk),
      .xrst (xrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Memories answer one cycle after the address
   always @(posedge clk) begin
      bus.x_rdata <= xmem[bus.x_raddr];
      for (int c = 0; c < NCH; c++)
         bus.w_rdata[c*DW +: DW] <= wmem[c][bus.w_raddr[c*AW +: AW]];
   end

   task automatic check(input string tag, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int yv(input int c);
      logic signed [OW-1:0] t;
      t = bus.y[c*OW +: OW];
      return int'(t);
   endfunction

   function automatic logic waddr_all(input logic [AW-1:0] a);
      for (int c = 0; c < NCH; c++)
         if (bus.w_raddr[c*AW +: AW] != a) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic setw(input int c, input int a0, input int a1, input int a2, input int a3);
      wmem[c][0] = DW'(a0); wmem[c][1] = DW'(a1);
      wmem[c][2] = DW'(a2); wmem[c][3] = DW'(a3);
   endtask

   task automatic fill(input int xv, input int wv);
      for (int i = 0; i < 16; i++) begin
         xmem[i] = DW'(xv);
         for (int c = 0; c < NCH; c++) wmem[c][i] = DW'(wv);
      end
   endtask

   task automatic load_t1();
      fill(99, 5);
      xmem[0] = 8'sd1; xmem[1] = 8'sd2; xmem[2] = 8'sd3; xmem[3] = 8'sd4;
      for (int c = 0; c < NCH; c++) setw(c, 0, 0, 0, 0);
      setw(0, 1, 1, 1, 1);
      setw(1, -10, -10, -10, -10);
      setw(3, 20, 20, 20, 20);
      setw(5, -1, 2, -3, 4);
      setw(6, 0, 0, -1, -31);
      setw(7, -1, 0, 0, -32);
      setw(8, 3, 0, 0, 31);
      setw(9, 0, 0, 0, 32);
   endtask

   // One pass started in the current cycle (cycle 0); observes cycles 1..win.
   // Extra start pulses at cycles p1/p2; len and relu are scrambled after cycle 0.
   task automatic run(input int l_in, input bit rl, input int win, input int p1, input int p2,
                      output int fin_cyc);
      int L;
      int nfin;
      bit addr_bad;
      bit busy_bad;
      logic [AW-1:0] ea;
      L = (l_in == 0) ? 16 : l_in;
      nfin = 0; addr_bad = 1'b0; busy_bad = 1'b0; fin_cyc = -1;
      bus.len = AW'(l_in); bus.relu = rl; bus.start = 1'b1;
      @(negedge clk);
      check("idle_busy_c0", int'(bus.busy), 0);
      @(posedge clk); #1;
      bus.start = (p1 == 1);
      bus.len   = AW'(l_in + 3);
      bus.relu  = ~rl;
      for (int cyc = 1; cyc <= win; cyc++) begin
         @(negedge clk);
         if (bus.busy != (cyc <= L + 2)) busy_bad = 1'b1;
         ea = AW'((cyc <= L) ? cyc - 1 : L - 1);
         if (bus.x_raddr != ea || !waddr_all(ea)) addr_bad = 1'b1;
         if (bus.finish) begin
            nfin++;
            if (fin_cyc < 0) fin_cyc = cyc;
         end
         if (cyc < win) begin
            @(posedge clk); #1;
            bus.start = (cyc + 1 == p1) || (cyc + 1 == p2);
         end
      end
      check($sformatf("busy_trace_len%0d", l_in), int'(busy_bad), 0);
      check($sformatf("addr_trace_len%0d", l_in), int'(addr_bad), 0);
      check($sformatf("finish_count_len%0d", l_in), nfin, 1);
      check($sformatf("finish_cycle_len%0d", l_in), fin_cyc, L + 2);
   endtask

   initial begin
      bit fseen;
      bus.start = 1'b0; bus.len = '0; bus.relu = 1'b0;
      load_t1();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_finish", int'(bus.finish), 0);
      check("rst_xaddr", int'(bus.x_raddr), 0);
      check("rst_waddr", int'(waddr_all('0)), 1);
      check("rst_y0", yv(0), 0);
      check("rst_y15", yv(15), 0);

      // Basic dot product, started in the first cycle after release
      xrst = 1'b1;
      run(4, 1'b0, 8, 0, 0, fcyc);
      check("t1_y0", yv(0), 10);
      check("t1_y1", yv(1), -100);
      check("t1_y2", yv(2), 0);
      check("t1_y3_sat", yv(3), 127);
      check("t1_y5", yv(5), 10);
      check("t1_y6", yv(6), -127);
      check("t1_y7_sat", yv(7), -128);
      check("t1_y8_edge", yv(8), 127);
      check("t1_y9_sat", yv(9), 127);
      tick();

      // Starts while busy and in DONE are ignored; next IDLE cycle accepts
      run(4, 1'b0, 6, 3, 6, fcyc);
      check("ign_y0", yv(0), 10);
      tick();
      run(4, 1'b0, 8, 0, 0, fcyc);
      check("restart_y5", yv(5), 10);
      tick();

      // Full-depth sweep with saturation
      fill(127, 127);
      run(0, 1'b0, 20, 0, 0, fcyc);
      check("sat_pos_y0", yv(0), 127);
      check("sat_pos_y15", yv(15), 127);
      tick();

      fill(127, -128);
      run(0, 1'b1, 18, 0, 0, fcyc);
      check("relu_y0", yv(0), 0);
      check("relu_y9", yv(9), 0);
      tick();

      run(0, 1'b0, 18, 0, 0, fcyc);
      check("sat_neg_y0", yv(0), -128);
      check("sat_neg_y15", yv(15), -128);
      tick();

      // Reset in cycle 3 of a len=8 pass
      load_t1();
      bus.len = AW'(8); bus.relu = 1'b0; bus.start = 1'b1;
      tick();
      tick();
      tick();
      xrst = 1'b0;
      #1;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_finish", int'(bus.finish), 0);
      check("abort_xaddr", int'(bus.x_raddr), 0);
      check("abort_waddr", int'(waddr_all('0)), 1);
      check("abort_y0", yv(0), 0);
      fseen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.finish) fseen = 1'b1;
      end
      check("abort_no_finish", int'(fseen), 0);
      @(posedge clk); #1;
      xrst = 1'b1;
      run(2, 1'b0, 6, 0, 0, fcyc);
      check("post_y0", yv(0), 3);
      check("post_y3", yv(3), 60);
      check("post_y5", yv(5), 3);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
